// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage. This block owns the program counter and issues
// in-order requests to instruction memory. Returned words are buffered with
// their PCs and handed to decode over a valid/ready handshake. A redirect
// from execute restarts fetch at the new target. It also discards every
// buffered instruction and every response still in flight from the old path.
//
// Parameters
//   BITS      data/address width (must match the execute stage)
//   RESET_PC  first fetch address after reset (multiple of 4)
//   DEPTH     instruction buffer entries and maximum outstanding requests
//             (power of two, at least 2)
//
// Ports
//   Clk        in   clock, all state updates on the rising edge
//   Rstn       in   asynchronous active-low reset
//   BjBus      in   redirect bus {BjEn, BjAddr}, all-zero when idle
//   IReqValid  out  fetch request valid
//   IReqAddr   out  fetch address (current fetch PC)
//   IReqReady  in   memory accepts the request this cycle
//   IRspValid  in   in-order memory response valid (no back-pressure)
//   IRspData   in   returned instruction word
//   InstValid  out  instruction available to decode
//   Inst       out  instruction word at buffer head
//   InstPC     out  address of Inst
//   InstReady  in   decode accepts the head this cycle
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int              BITS     = 32,
    parameter logic [BITS-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            Clk,
    input  logic            Rstn,
    input  logic [BITS:0]   BjBus,
    output logic            IReqValid,
    output logic [BITS-1:0] IReqAddr,
    input  logic            IReqReady,
    input  logic            IRspValid,
    input  logic [BITS-1:0] IRspData,
    output logic            InstValid,
    output logic [BITS-1:0] Inst,
    output logic [BITS-1:0] InstPC,
    input  logic            InstReady
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW:0]   PTR_ONE   = (AW + 1)'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW:0]   DEPTH_LIM = (CW + 1)'(DEPTH);

    // Program counter of the next request
    logic [BITS-1:0] fetch_pc;

    // Tag FIFO: addresses of outstanding requests whose responses will be kept
    logic [BITS-1:0] tag_mem [DEPTH];
    logic [AW:0]     tag_wr;
    logic [AW:0]     tag_rd;

    // Instruction FIFO: {word, pc} pairs waiting for decode
    logic [BITS-1:0] inst_mem [DEPTH];
    logic [BITS-1:0] pc_mem   [DEPTH];
    logic [AW:0]     ib_wr;
    logic [AW:0]     ib_rd;

    // Outstanding requests (including ones whose responses will be dropped)
    // and the number of upcoming responses that belong to a discarded path
    logic [CW-1:0]   osd;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   osd_next;
    logic [CW-1:0]   inst_count;

    logic            bj_en;
    logic [BITS-1:0] bj_target;
    logic            cred;
    logic            req_fire;
    logic            rsp_drop;
    logic            rsp_keep;
    logic            pop;

    assign bj_en     = BjBus[BITS];
    assign bj_target = BjBus[BITS-1:0] & ~BITS'(3);

    // Pointers carry one extra wrap bit, so the difference is the occupancy
    assign inst_count = ib_wr - ib_rd;

    // A request is only issued when every outstanding response is
    // guaranteed a buffer slot. This is why responses never need back-pressure.
    assign cred = ({1'b0, osd} + {1'b0, inst_count}) < DEPTH_LIM;

    // Gating with Rstn keeps the memory interface quiet while reset is held.
    // Without the gate, the freshly cleared credit would already look like a request.
    assign IReqValid = Rstn & cred & ~bj_en;
    assign IReqAddr  = fetch_pc;
    assign req_fire  = IReqValid & IReqReady;

    // A response in a redirect cycle belongs to the old path by definition
    assign rsp_drop = IRspValid & (bj_en | (drop_cnt != '0));
    assign rsp_keep = IRspValid & ~rsp_drop;

    assign osd_next = osd + CW'(req_fire) - CW'(IRspValid);

    assign InstValid = (ib_wr != ib_rd);
    assign pop       = InstValid & InstReady;

    // Storage arrays are not reset, so the outputs are masked while the
    // buffer is empty. This keeps Inst/InstPC at zero after reset and flush.
    assign Inst   = InstValid ? inst_mem[ib_rd[AW-1:0]] : '0;
    assign InstPC = InstValid ? pc_mem[ib_rd[AW-1:0]]   : '0;

    // Control state: PC, FIFO pointers and the two counters
    always_ff @(posedge Clk or negedge Rstn) begin
        if (!Rstn) begin
            fetch_pc <= RESET_PC;
            tag_wr   <= '0;
            tag_rd   <= '0;
            ib_wr    <= '0;
            ib_rd    <= '0;
            osd      <= '0;
            drop_cnt <= '0;
        end else begin
            osd <= osd_next;

            if (bj_en) begin
                // No request fires in a redirect cycle, so osd_next counts
                // exactly the old-path requests still waiting for a response.
                fetch_pc <= bj_target;
                tag_wr   <= '0;
                tag_rd   <= '0;
                ib_wr    <= '0;
                ib_rd    <= '0;
                drop_cnt <= osd_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + BITS'(4);
                    tag_wr   <= tag_wr + PTR_ONE;
                end
                if (rsp_keep) begin
                    tag_rd <= tag_rd + PTR_ONE;
                    ib_wr  <= ib_wr + PTR_ONE;
                end
                if (rsp_drop) begin
                    drop_cnt <= drop_cnt - CNT_ONE;
                end
                if (pop) begin
                    ib_rd <= ib_rd + PTR_ONE;
                end
            end
        end
    end

    // FIFO storage. Writes are already suppressed in redirect cycles,
    // because req_fire and rsp_keep are both low there.
    always_ff @(posedge Clk) begin
        if (req_fire) begin
            tag_mem[tag_wr[AW-1:0]] <= fetch_pc;
        end
        if (rsp_keep) begin
            inst_mem[ib_wr[AW-1:0]] <= IRspData;
            pc_mem[ib_wr[AW-1:0]]   <= tag_mem[tag_rd[AW-1:0]];
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Testbench for fetch_unit. The main instance uses RESET_PC=0 and DEPTH=4.
// A second instance uses RESET_PC=0xFFFFFFF8 and DEPTH=2 to show PC
// wrap-around. The reference model tracks the program in terms of
// in-flight requests (each one marked stale or live) and a queue of
// instructions waiting for decode.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

   localparam int          BITS    = 32;
   localparam int          DEPTH   = 4;
   localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

   logic        Clk  = 1'b0;
   logic        Rstn = 1'b1;
   logic [32:0] BjBus;
   logic        IReqValid;
   logic [31:0] IReqAddr;
   logic        IReqReady;
   logic        IRspValid;
   logic [31:0] IRspData;
   logic        InstValid;
   logic [31:0] Inst;
   logic [31:0] InstPC;
   logic        InstReady;

   logic [32:0] wBjBus;
   logic        wIReqValid;
   logic [31:0] wIReqAddr;
   logic        wIReqReady;
   logic        wIRspValid;
   logic [31:0] wIRspData;
   logic        wInstValid;
   logic [31:0] wInst;
   logic [31:0] wInstPC;
   logic        wInstReady;

   always #5 Clk = ~Clk;

   fetch_unit #(.BITS(BITS), .RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
      .Clk(Clk), .Rstn(Rstn), .BjBus(BjBus),
      .IReqValid(IReqValid), .IReqAddr(IReqAddr), .IReqReady(IReqReady),
      .IRspValid(IRspValid), .IRspData(IRspData),
      .InstValid(InstValid), .Inst(Inst), .InstPC(InstPC), .InstReady(InstReady)
   );

   fetch_unit #(.BITS(BITS), .RESET_PC(WRAP_PC), .DEPTH(2)) dutWrap (
      .Clk(Clk), .Rstn(Rstn), .BjBus(wBjBus),
      .IReqValid(wIReqValid), .IReqAddr(wIReqAddr), .IReqReady(wIReqReady),
      .IRspValid(wIRspValid), .IRspData(wIRspData),
      .InstValid(wInstValid), .Inst(wInst), .InstPC(wInstPC), .InstReady(wInstReady)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
      bit          stale;
   } ReqT;

   typedef struct {
      logic [31:0] word;
      logic [31:0] pc;
   } EntT;

   ReqT         inflight[$];
   EntT         buffer[$];
   logic [31:0] modelPc;
   int          cyc = 0;
   int          lastDue = -1;
   int          latMin = 1;
   int          latMax = 1;
   logic [31:0] obsLog[$];
   int          obsCyc[$];
   logic [31:0] wLog[$];
   bit          wPend;
   logic [31:0] wPendAddr;
   int          acceptCount;
   bit          lastInstValid;

   int          checks = 0;
   int          errors = 0;

   // Instruction memory contents: an odd-multiplier hash keeps words distinct per address
   function automatic logic [31:0] instrFor(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic checkFlag(input string tag, input logic observed, input logic expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic resetModel();
      inflight.delete();
      buffer.delete();
      modelPc   = 32'h0;
      lastDue   = cyc - 1;
      wPend     = 1'b0;
      wPendAddr = '0;
   endtask

   // One clock cycle. It drives the memory responses and compares every
   // output against the model. It then advances the model across the rising edge.
   task automatic applyStimulus();
      bit          bjEn;
      bit          expReqValid;
      bit          popDec;
      bit          rspNow;
      bit          wFire;
      logic [31:0] wAddr;
      ReqT         r;
      int          due;
      int          lat;

      if (inflight.size() > 0 && inflight[0].due <= cyc) begin
         IRspValid = 1'b1;
         IRspData  = instrFor(inflight[0].addr);
      end else begin
         IRspValid = 1'b0;
         IRspData  = $urandom;
      end
      wIRspValid = wPend;
      wIRspData  = instrFor(wPendAddr);
      #1;

      bjEn        = BjBus[32];
      expReqValid = (inflight.size() + buffer.size() < DEPTH) && !bjEn;
      checkFlag("ireq_valid", IReqValid, expReqValid);
      checkOutput("ireq_addr", IReqAddr, modelPc);
      checkFlag("inst_valid", InstValid, buffer.size() != 0);
      if (buffer.size() != 0) begin
         checkOutput("inst", Inst, buffer[0].word);
         checkOutput("inst_pc", InstPC, buffer[0].pc);
      end
      lastInstValid = InstValid;
      if (InstValid && InstReady) begin
         obsLog.push_back(InstPC);
         obsCyc.push_back(cyc);
      end
      if (IReqValid && IReqReady) acceptCount++;
      if (wInstValid && wInstReady) wLog.push_back(wInstPC);
      wFire = wIReqValid & wIReqReady;
      wAddr = wIReqAddr;
      rspNow = IRspValid;

      @(posedge Clk);

      popDec = (buffer.size() != 0) && InstReady;
      if (rspNow) begin
         r = inflight.pop_front();
         if (!r.stale && !bjEn) buffer.push_back('{word: instrFor(r.addr), pc: r.addr});
      end
      if (popDec) void'(buffer.pop_front());
      if (expReqValid && IReqReady) begin
         lat = int'($urandom_range(latMax, latMin));
         due = cyc + lat;
         if (due <= lastDue) due = lastDue + 1;
         lastDue = due;
         inflight.push_back('{addr: modelPc, due: due, stale: 1'b0});
         modelPc = modelPc + 32'd4;
      end
      if (bjEn) begin
         buffer.delete();
         foreach (inflight[i]) inflight[i].stale = 1'b1;
         modelPc = {BjBus[31:2], 2'b00};
      end
      cyc++;
      wPend     = wFire;
      wPendAddr = wAddr;
      @(negedge Clk);
   endtask

   task automatic doReset();
      Rstn       = 1'b0;
      BjBus      = '0;
      IReqReady  = 1'b0;
      InstReady  = 1'b0;
      IRspValid  = 1'b0;
      IRspData   = '0;
      wIRspValid = 1'b0;
      #1;
      checkFlag("rst_ireq_valid", IReqValid, 1'b0);
      checkOutput("rst_ireq_addr", IReqAddr, 32'h0);
      checkFlag("rst_inst_valid", InstValid, 1'b0);
      checkOutput("rst_inst", Inst, 32'h0);
      checkOutput("rst_inst_pc", InstPC, 32'h0);
      checkOutput("rst_wrap_addr", wIReqAddr, WRAP_PC);
      checkFlag("rst_wrap_valid", wIReqValid, 1'b0);
      repeat (2) @(negedge Clk);
      checkFlag("rst_hold_ireq_valid", IReqValid, 1'b0);
      Rstn = 1'b1;
      resetModel();
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      BjBus      = '0;
      IReqReady  = 1'b0;
      InstReady  = 1'b0;
      IRspValid  = 1'b0;
      IRspData   = '0;
      wBjBus     = '0;
      wIReqReady = 1'b1;
      wInstReady = 1'b1;
      wIRspValid = 1'b0;
      wIRspData  = '0;
      #2;

      // Reset, then stream with a 1-cycle memory
      doReset();
      $display("[TB] stream after reset");
      IReqReady = 1'b1;
      InstReady = 1'b1;
      latMin = 1; latMax = 1;
      obsLog.delete(); obsCyc.delete(); wLog.delete();
      repeat (12) applyStimulus();
      checkFlag("stream_count", obsLog.size() >= 4, 1'b1);
      checkOutput("stream_pc0", obsLog[0], 32'h0);
      checkOutput("stream_pc1", obsLog[1], 32'h4);
      checkOutput("stream_pc2", obsLog[2], 32'h8);
      checkOutput("stream_pc3", obsLog[3], 32'hC);
      checkOutput("stream_rate", 32'(obsCyc[3] - obsCyc[0]), 32'd3);
      checkFlag("wrap_count", wLog.size() >= 3, 1'b1);
      checkOutput("wrap_pc0", wLog[0], 32'hFFFF_FFF8);
      checkOutput("wrap_pc1", wLog[1], 32'hFFFF_FFFC);
      checkOutput("wrap_pc2", wLog[2], 32'h0000_0000);

      // Back-pressure: decode stalls and fetch must stop after DEPTH requests
      doReset();
      $display("[TB] back-pressure");
      IReqReady = 1'b1;
      InstReady = 1'b0;
      acceptCount = 0;
      repeat (10) applyStimulus();
      checkOutput("bp_accepts", 32'(acceptCount), 32'(DEPTH));
      checkFlag("bp_ireq_stalled", IReqValid, 1'b0);
      InstReady = 1'b1;
      obsLog.delete();
      repeat (15) applyStimulus();
      for (int i = 0; i < 6; i++) checkOutput("bp_order", obsLog[i], 32'(4 * i));

      // Redirect with two requests in flight on a 3-cycle memory
      doReset();
      $display("[TB] redirect with in-flight requests");
      IReqReady = 1'b1;
      InstReady = 1'b1;
      latMin = 3; latMax = 3;
      repeat (2) applyStimulus();
      BjBus = {1'b1, 32'h100};
      applyStimulus();
      BjBus = '0;
      obsLog.delete();
      repeat (12) applyStimulus();
      checkOutput("redir_pc0", obsLog[0], 32'h100);
      checkOutput("redir_pc1", obsLog[1], 32'h104);

      // Redirect landing on a response and a decode pop, unaligned target
      doReset();
      $display("[TB] redirect with response and pop");
      IReqReady = 1'b1;
      InstReady = 1'b1;
      latMin = 1; latMax = 1;
      repeat (6) applyStimulus();
      BjBus = {1'b1, 32'h203};
      applyStimulus();
      checkFlag("redir2_pop_cycle", lastInstValid, 1'b1);
      BjBus = '0;
      #1;
      checkFlag("redir2_inst_valid", InstValid, 1'b0);
      checkOutput("redir2_addr", IReqAddr, 32'h200);
      checkFlag("redir2_req_valid", IReqValid, 1'b1);
      obsLog.delete();
      repeat (8) applyStimulus();
      checkOutput("redir2_pc0", obsLog[0], 32'h200);

      // Asynchronous reset between edges with the buffer full
      $display("[TB] async reset mid-stream");
      InstReady = 1'b0;
      repeat (8) applyStimulus();
      checkFlag("full_before_reset", InstValid, 1'b1);
      doReset();
      IReqReady = 1'b1;
      InstReady = 1'b1;
      obsLog.delete();
      repeat (8) applyStimulus();
      checkOutput("restart_pc0", obsLog[0], 32'h0);
      checkOutput("restart_pc1", obsLog[1], 32'h4);

      // Randomised traffic with variable latency and random redirects
      $display("[TB] random traffic");
      latMin = 1; latMax = 3;
      for (int i = 0; i < 400; i++) begin
         IReqReady = ($urandom_range(3, 0) != 0);
         InstReady = ($urandom_range(3, 0) != 0);
         if ($urandom_range(15, 0) == 0) BjBus = {1'b1, 32'($urandom)};
         else BjBus = '0;
         applyStimulus();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
